photon_rate_meter: RTL and testbench
====================================

// Module: photon_rate_meter
// PURPOSE
// - Front-end conditioner for the asynchronous APD photon input, upstream of the laser/AOM protection stage.
// - Synchronises photon pulses into clk, detects rising edges and applies a dead-time lockout.
// - Emits a single-cycle photon_pulse per accepted photon.
// - Counts accepted photons over fixed windows; each window's count goes to the protection threshold compare.
// PARAMETERS
// - CNT_W        25       width of window photon count
// - WIN_CYCLES   8388608  window length in clk cycles (>=4)
// - DEADTIME     4        clk cycles after an accepted edge during which new edges are ignored (>=0)
// - SYNC_STAGES  2        flip-flops in photon_in synchroniser (>=2)
// PORTS
// - clk          in   1      system clock
// - reset        in   1      synchronous, active-high
// - photon_in    in   1      raw APD pulse, asynchronous to clk, min high/low time 1 clk
// - enable       in   1      1 = measure; 0 = hold window logic idle
// - photon_pulse out  1      1-cycle strobe per accepted photon
// - win_count    out  CNT_W  photon count of last completed window (saturating)
// - win_valid    out  1      1-cycle strobe: win_count/win_ovf just updated
// - win_ovf      out  1      last completed window saturated at 2^CNT_W-1
// BEHAVIOUR
// Reset
// - All synchroniser flops, edge register, dead-time counter, window timer and accumulator cleared.
// - photon_pulse=0, win_count=0, win_valid=0, win_ovf=0.
// Synchroniser and edge
// - sync[0..SYNC_STAGES-1] shift register; prev <= sync[last].
// - edge = sync[last] & ~prev.
// Dead time
// - dt_cnt counts down to 0.
// - Edge with dt_cnt==0 is accepted: registered photon_pulse=1 next cycle, dt_cnt <= DEADTIME.
// - Edge with dt_cnt!=0 is dropped; dt_cnt is not retriggered.
// - DEADTIME=0: every edge is accepted.
// Latency
// - photon_in rising -> photon_pulse high exactly SYNC_STAGES+1 clk later.
// - photon_pulse is never high two cycles running.
// State machine (2 states)
// - IDLE: timer=0, acc=0, photon_pulse forced 0, win_valid=0. Synchroniser and dead time keep running.
// - IDLE -> COUNT when enable=1 (next cycle is window cycle 0).
// - COUNT: timer increments 0..WIN_CYCLES-1.
// - COUNT -> IDLE when enable=0: partial window discarded, no win_valid; win_count holds last value.
// Window close
// - On timer==WIN_CYCLES-1: win_count <= acc + photon_pulse (saturated); win_ovf <= saturated; win_valid=1 for 1 cycle.
// - Same cycle: acc <= 0, timer <= 0. A pulse in the terminal cycle belongs to the closing window.
// Arithmetic
// - acc is CNT_W bits, saturating at 2^CNT_W-1; sticky ovf_acc set when a pulse arrives at max.
// - ovf_acc cleared at window close.
// - Window timer width is clog2(WIN_CYCLES); wraps only via the close rule.
// Reset mid-window
// - Reset overrides everything: state IDLE, outputs as reset; no win_valid emitted for the aborted window.
// TESTING
// - Params for all tests: WIN_CYCLES=16, DEADTIME=3, CNT_W=4, SYNC_STAGES=2.
// - Single pulse: photon_in high 2 cycles at t0 -> photon_pulse=1 at t0+3 only.
// - Dead time: edges 2 cycles apart x3 -> only 1st and 3rd accepted; 2 pulses.
// - Window: enable=1, 5 spaced photons (gap>=5) -> win_valid at cycle 16 with win_count=5, win_ovf=0, then a 2nd window with count 0.
// - Saturation: 20 photons (gap 4) with WIN_CYCLES=128 -> win_count=15, win_ovf=1; following empty window -> win_count=0, win_ovf=0.
// - Boundary: photon accepted on terminal window cycle -> counted in closing window; next window acc starts at 0.
// - Disable/reset: enable=0 at cycle 8 -> no win_valid, win_count holds; reset mid-window -> all outputs 0 next cycle.

Source files
------------

// File: rtl/photon_rate_meter.sv
// APD photon front end: synchronises the raw photon input, applies a dead-time lockout and
// counts accepted photons over fixed windows for the downstream protection threshold compare.
module photon_rate_meter #(
    parameter int CNT_W       = 25,
    parameter int WIN_CYCLES  = 8388608,
    parameter int DEADTIME    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             photon_in,
    input  logic             enable,
    output logic             photon_pulse,
    output logic [CNT_W-1:0] win_count,
    output logic             win_valid,
    output logic             win_ovf
);

    localparam int TMR_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam int DT_W  = $clog2(DEADTIME + 2);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_CYCLES - 1);
    localparam logic [DT_W-1:0]  DT_LOAD  = DT_W'(DEADTIME);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   edge_det;
    logic                   accept;
    logic [DT_W-1:0]        dt_cnt;
    logic                   pulse_p1;

    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] acc;
    logic             ovf_acc;
    logic [CNT_W-1:0] acc_inc;
    logic             inc_ovf;
    logic             closing;
    logic             run;

    // Saturating increment: returns {hit_max, next_value}.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
        if (inc && (a == CNT_MAX)) begin
            return {1'b1, CNT_MAX};
        end
        return {1'b0, a + CNT_W'(inc)};
    endfunction

    // Stage 0: synchroniser and edge history
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], photon_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync[SYNC_STAGES-1] & ~prev;
    assign accept   = edge_det & (dt_cnt == '0);

    // Stage 1: dead-time lockout and registered pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            dt_cnt   <= '0;
            pulse_p1 <= 1'b0;
        end else begin
            pulse_p1 <= accept;
            if (accept) begin
                dt_cnt <= DT_LOAD;
            end else if (dt_cnt != '0) begin
                dt_cnt <= dt_cnt - DT_W'(1);
            end
        end
    end

    // The lockout keeps running while idle; only the visible strobe is gated.
    assign photon_pulse = pulse_p1 & (state == COUNT);

    assign {inc_ovf, acc_inc} = sat_inc(acc, photon_pulse);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        closing   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    run     = 1'b1;
                    closing = (timer == TMR_LAST);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 2: window timer, accumulator and published result
    always_ff @(posedge clk) begin
        if (reset) begin
            timer     <= '0;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            win_count <= '0;
            win_ovf   <= 1'b0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= closing;
            if (!run || closing) begin
                timer   <= '0;
                acc     <= '0;
                ovf_acc <= 1'b0;
            end else begin
                timer   <= timer + TMR_W'(1);
                acc     <= acc_inc;
                ovf_acc <= ovf_acc | inc_ovf;
            end
            // A pulse in the terminal cycle still belongs to the closing window.
            if (closing) begin
                win_count <= acc_inc;
                win_ovf   <= ovf_acc | inc_ovf;
            end
        end
    end

endmodule

// File: tb/tb_photon_rate_meter.sv
// Directed bench for photon_rate_meter: expected pulses and window results are queued
// when stimulus is driven and checked when the DUT produces them.
module tb_photon_rate_meter;

    logic       clk = 1'b0;
    logic       reset;
    logic       photon_in_a, enable_a, photon_pulse_a, win_valid_a, win_ovf_a;
    logic [3:0] win_count_a;
    logic       photon_in_b, enable_b, photon_pulse_b, win_valid_b, win_ovf_b;
    logic [3:0] win_count_b;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int         cyc;
        logic [3:0] cnt;
        logic       ovf;
    } win_t;

    int   pq_a[$];
    int   pq_b[$];
    win_t wq_a[$];
    win_t wq_b[$];

    photon_rate_meter #(.CNT_W(4), .WIN_CYCLES(16), .DEADTIME(3), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset), .photon_in(photon_in_a), .enable(enable_a),
        .photon_pulse(photon_pulse_a), .win_count(win_count_a),
        .win_valid(win_valid_a), .win_ovf(win_ovf_a)
    );

    photon_rate_meter #(.CNT_W(4), .WIN_CYCLES(128), .DEADTIME(3), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .reset(reset), .photon_in(photon_in_b), .enable(enable_b),
        .photon_pulse(photon_pulse_b), .win_count(win_count_b),
        .win_valid(win_valid_b), .win_ovf(win_ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic pulse_a(input int t, input int hi);
        goto(t);
        photon_in_a = 1'b1;
        step(hi);
        photon_in_a = 1'b0;
    endtask

    task automatic pulse_b(input int t, input int hi);
        goto(t);
        photon_in_b = 1'b1;
        step(hi);
        photon_in_b = 1'b0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        logic ev;
        win_t w;
        ev = (pq_a.size() > 0) && (pq_a[0] == cyc);
        if (ev || photon_pulse_a) begin
            tests++;
            assert (photon_pulse_a === ev) else begin
                fails++;
                $error("FAIL pulse_a cycle %0d: observed %0b expected %0b", cyc, photon_pulse_a, ev);
            end
            if (ev) void'(pq_a.pop_front());
        end
        ev = (wq_a.size() > 0) && (wq_a[0].cyc == cyc);
        if (ev) begin
            w = wq_a.pop_front();
        end else begin
            w.cyc = -1; w.cnt = 4'd0; w.ovf = 1'b0;
        end
        if (ev || win_valid_a) begin
            tests++;
            assert ({win_valid_a, win_count_a, win_ovf_a} === {ev, w.cnt, w.ovf}) else begin
                fails++;
                $error("FAIL window_a cycle %0d: observed valid=%0b count=%0d ovf=%0b expected valid=%0b count=%0d ovf=%0b",
                       cyc, win_valid_a, win_count_a, win_ovf_a, ev, w.cnt, w.ovf);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic ev;
        win_t w;
        ev = (pq_b.size() > 0) && (pq_b[0] == cyc);
        if (ev || photon_pulse_b) begin
            tests++;
            assert (photon_pulse_b === ev) else begin
                fails++;
                $error("FAIL pulse_b cycle %0d: observed %0b expected %0b", cyc, photon_pulse_b, ev);
            end
            if (ev) void'(pq_b.pop_front());
        end
        ev = (wq_b.size() > 0) && (wq_b[0].cyc == cyc);
        if (ev) begin
            w = wq_b.pop_front();
        end else begin
            w.cyc = -1; w.cnt = 4'd0; w.ovf = 1'b0;
        end
        if (ev || win_valid_b) begin
            tests++;
            assert ({win_valid_b, win_count_b, win_ovf_b} === {ev, w.cnt, w.ovf}) else begin
                fails++;
                $error("FAIL window_b cycle %0d: observed valid=%0b count=%0d ovf=%0b expected valid=%0b count=%0d ovf=%0b",
                       cyc, win_valid_b, win_count_b, win_ovf_b, ev, w.cnt, w.ovf);
            end
        end
    end

    initial begin
        int e;
        reset       = 1'b1;
        photon_in_a = 1'b0;
        enable_a    = 1'b0;
        photon_in_b = 1'b0;
        enable_b    = 1'b0;
        step(3);
        check("reset photon_pulse_a", int'(photon_pulse_a), 0);
        check("reset win_count_a",    int'(win_count_a),    0);
        check("reset win_valid_a",    int'(win_valid_a),    0);
        check("reset win_ovf_a",      int'(win_ovf_a),      0);
        check("reset photon_pulse_b", int'(photon_pulse_b), 0);
        check("reset win_count_b",    int'(win_count_b),    0);
        check("reset win_valid_b",    int'(win_valid_b),    0);
        check("reset win_ovf_b",      int'(win_ovf_b),      0);
        reset = 1'b0;
        step(2);

        // Single pulse, dead-time drop, then a counted window and an empty one.
        e = cyc;
        enable_a = 1'b1;
        pq_a.push_back(e + 4);
        pq_a.push_back(e + 9);
        pq_a.push_back(e + 13);
        wq_a.push_back('{e + 17, 4'd3, 1'b0});
        wq_a.push_back('{e + 33, 4'd0, 1'b0});
        pulse_a(e + 1, 2);
        pulse_a(e + 6, 1);
        pulse_a(e + 8, 1);
        pulse_a(e + 10, 1);
        goto(e + 33);
        enable_a = 1'b0;
        step(4);

        // Terminal-cycle photon, fresh next window, then disable at window cycle 8.
        e = cyc;
        enable_a = 1'b1;
        pq_a.push_back(e + 8);
        pq_a.push_back(e + 16);
        pq_a.push_back(e + 20);
        pq_a.push_back(e + 37);
        wq_a.push_back('{e + 17, 4'd2, 1'b0});
        wq_a.push_back('{e + 33, 4'd1, 1'b0});
        pulse_a(e + 5, 2);
        pulse_a(e + 13, 2);
        pulse_a(e + 17, 2);
        pulse_a(e + 34, 2);
        goto(e + 41);
        enable_a = 1'b0;
        step(30);
        check("hold win_count_a", int'(win_count_a), 1);
        check("hold win_ovf_a",   int'(win_ovf_a),   0);

        // Reset in the middle of a window with a photon in flight.
        e = cyc;
        enable_a = 1'b1;
        pq_a.push_back(e + 5);
        pulse_a(e + 2, 2);
        pulse_a(e + 6, 2);
        goto(e + 8);
        reset = 1'b1;
        step(1);
        check("midreset photon_pulse_a", int'(photon_pulse_a), 0);
        check("midreset win_count_a",    int'(win_count_a),    0);
        check("midreset win_valid_a",    int'(win_valid_a),    0);
        check("midreset win_ovf_a",      int'(win_ovf_a),      0);
        enable_a = 1'b0;
        step(1);
        reset = 1'b0;
        step(40);

        // Saturation on the long-window instance, then an empty window.
        e = cyc;
        enable_b = 1'b1;
        for (int k = 0; k < 20; k++) pq_b.push_back(e + 4 + 4 * k);
        wq_b.push_back('{e + 129, 4'd15, 1'b1});
        wq_b.push_back('{e + 257, 4'd0, 1'b0});
        for (int k = 0; k < 20; k++) pulse_b(e + 1 + 4 * k, 2);
        goto(e + 257);
        enable_b = 1'b0;
        step(5);

        check("pending pulses a",  pq_a.size(), 0);
        check("pending windows a", wq_a.size(), 0);
        check("pending pulses b",  pq_b.size(), 0);
        check("pending windows b", wq_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
